// File: rtl/tape_reader_tx_pkg.sv
// Shared types and constants for the paper-tape reader transmitter.
package tape_reader_tx_pkg;

  // Pass sequencer states.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEAD,
    ST_FETCH,
    ST_WAITD,
    ST_SEND,
    ST_TRAIL,
    ST_DONE
  } state_e;

  // Blank-tape byte (feed holes only) sent as leader and trailer.
  localparam logic [7:0] LEADER_BYTE = 8'o200;

  // Bits in one async frame: start + 8 data + stop bits.
  function automatic int frame_bits(input int stop_bits);
    return 9 + stop_bits;
  endfunction

endpackage

// File: rtl/tape_reader_tx_if.sv
// Synchronous tape-image byte-store read port.
interface tape_reader_tx_if #(
  parameter int AW = 12
);
  logic [AW-1:0] tape_addr;
  logic          tape_rd;
  logic [7:0]    tape_data;

  // Reader side issues addresses and read strobes.
  modport master (
    output tape_addr,
    output tape_rd,
    input  tape_data
  );

  // Store side returns data one clock after the strobe.
  modport slave (
    input  tape_addr,
    input  tape_rd,
    output tape_data
  );
endinterface

// File: rtl/uart_frame_tx.sv
// Async frame serialiser: start bit, 8 data bits LSB first, STOP_BITS stop bits.
module uart_frame_tx
  import tape_reader_tx_pkg::*;
#(
  parameter int DIVISOR   = 10417,
  parameter int STOP_BITS = 2
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       load,
  input  logic [7:0] data,
  output logic       txd,
  output logic       frame_busy,
  output logic       frame_end
);

  localparam int          NBITS      = frame_bits(STOP_BITS);
  localparam logic [15:0] TIMER_LAST = 16'(DIVISOR - 1);
  localparam logic [3:0]  BIT_LAST   = 4'(NBITS - 1);

  logic [15:0]          timer_q;
  logic [3:0]           bit_q;
  logic [7+STOP_BITS:0] shift_q;
  logic                 txd_q;
  logic                 busy_q;
  logic                 bit_done;

  // A bit period ends when the timer reaches DIVISOR-1; frame_end flags the
  // final clock of the last stop bit so the caller can react on that edge.
  assign bit_done   = busy_q && (timer_q == TIMER_LAST);
  assign frame_end  = bit_done && (bit_q == BIT_LAST);
  assign txd        = txd_q;
  assign frame_busy = busy_q;

  // Bit timer, bit counter and shift register; txd is driven from a flop.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      timer_q <= '0;
      bit_q   <= '0;
      shift_q <= '1;
      txd_q   <= 1'b1;
      busy_q  <= 1'b0;
    end else if (load && !busy_q) begin
      timer_q <= '0;
      bit_q   <= '0;
      shift_q <= {{STOP_BITS{1'b1}}, data};
      txd_q   <= 1'b0;
      busy_q  <= 1'b1;
    end else if (bit_done) begin
      timer_q <= '0;
      if (frame_end) begin
        bit_q  <= '0;
        txd_q  <= 1'b1;
        busy_q <= 1'b0;
      end else begin
        bit_q   <= bit_q + 4'd1;
        txd_q   <= shift_q[0];
        shift_q <= {1'b1, shift_q[7+STOP_BITS:1]};
      end
    end else if (busy_q) begin
      timer_q <= timer_q + 16'd1;
    end
  end

endmodule

// File: rtl/tape_reader_tx.sv
// ASR-33 paper-tape reader emulation: leader, tape image, trailer on txd.
module tape_reader_tx
  import tape_reader_tx_pkg::*;
#(
  parameter int DIVISOR    = 10417,
  parameter int STOP_BITS  = 2,
  parameter int LEADER_LEN = 16,
  parameter int AW         = 12
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          start,
  input  logic [AW-1:0] tape_len,
  input  logic          pause,
  tape_reader_tx_if.master tape,
  output logic          txd,
  output logic          busy,
  output logic          done
);

  localparam int            CW        = (LEADER_LEN > 0) ? $clog2(LEADER_LEN + 1) : 1;
  localparam logic [CW-1:0] LEAD_LAST = CW'(LEADER_LEN);

  state_e        state_q;
  logic [AW-1:0] len_q;
  logic [AW-1:0] idx_q;
  logic [AW-1:0] addr_q;
  logic [CW-1:0] cnt_q;
  logic [7:0]    byte_q;
  logic          first_q;
  logic          rd_q;
  logic          busy_q;
  logic          done_q;

  logic          frame_load;
  logic [7:0]    frame_data;
  logic          frame_busy;
  logic          frame_end;
  logic          lead_more;

  assign lead_more      = (cnt_q != LEAD_LAST);
  assign tape.tape_addr = addr_q;
  assign tape.tape_rd   = rd_q;
  assign busy           = busy_q;
  assign done           = done_q;

  // Hand a byte to the serialiser only at a frame boundary and only while
  // pause is low. The store word is valid in the first WAITD clock only, so
  // a paused WAITD replays the copy captured in byte_q.
  always_comb begin
    frame_load = 1'b0;
    frame_data = LEADER_BYTE;
    case (state_q)
      ST_LEAD, ST_TRAIL: frame_load = lead_more && !frame_busy && !pause;
      ST_WAITD: begin
        frame_load = !pause;
        frame_data = first_q ? tape.tape_data : byte_q;
      end
      default: ;
    endcase
  end

  // Pass sequencer; tape_rd/tape_addr are set on the edge entering FETCH so
  // the strobe occupies exactly the FETCH clock.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      len_q   <= '0;
      idx_q   <= '0;
      addr_q  <= '0;
      cnt_q   <= '0;
      byte_q  <= '0;
      first_q <= 1'b0;
      rd_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      rd_q   <= 1'b0;
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_q <= ST_LEAD;
            len_q   <= tape_len;
            idx_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        ST_LEAD: begin
          if (!lead_more) begin
            if (frame_end || !frame_busy) begin
              state_q <= ST_FETCH;
              addr_q  <= idx_q;
              rd_q    <= (idx_q != len_q);
            end
          end else if (frame_load) begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        ST_FETCH: begin
          if (idx_q == len_q) begin
            state_q <= ST_TRAIL;
            cnt_q   <= '0;
          end else begin
            state_q <= ST_WAITD;
            first_q <= 1'b1;
          end
        end
        ST_WAITD: begin
          first_q <= 1'b0;
          if (first_q) begin
            byte_q <= tape.tape_data;
          end
          if (!pause) begin
            idx_q   <= idx_q + AW'(1);
            state_q <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (frame_end) begin
            state_q <= ST_FETCH;
            addr_q  <= idx_q;
            rd_q    <= (idx_q != len_q);
          end
        end
        ST_TRAIL: begin
          if (!lead_more) begin
            if (frame_end || !frame_busy) begin
              state_q <= ST_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end else if (frame_load) begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  uart_frame_tx #(
    .DIVISOR   (DIVISOR),
    .STOP_BITS (STOP_BITS)
  ) u_frame (
    .clk        (clk),
    .resetn     (resetn),
    .load       (frame_load),
    .data       (frame_data),
    .txd        (txd),
    .frame_busy (frame_busy),
    .frame_end  (frame_end)
  );

endmodule

// File: doc/tape_reader_tx.md
Name: tape_reader_tx

Overview:
- Emulates an ASR-33 paper-tape reader feeding the console receive line (`rx`) of the KL8E serial block.
- It is the transmit end of that serial link: it reads a tape image from a synchronous byte store and serialises it as async 8-data-bit frames.
- Each tape is framed by leader and trailer bytes.
- Sits beside the CPU, clocked by `clk100`; its `txd` drives the CPU `rx` input when bench/boot loading.

Parameters:
- DIVISOR, 10417 — clocks per bit (100 MHz / 9600 baud); legal range 2..65535.
- STOP_BITS, 2 — stop bits per frame, 1 or 2.
- LEADER_LEN, 16 — count of 0200 leader bytes before data and trailer bytes after data; 0 allowed.
- AW, 12 — tape store address width.

Ports:
- clk  in  1  system clock (`clk100`)
- resetn  in  1  synchronous, active-low reset
- start  in  1  single-cycle pulse; begins a tape pass when idle
- tape_len  in  AW  number of data bytes, sampled on accepted start; 0 means leader+trailer only
- pause  in  1  XOFF-style hold; frames in progress complete, no new frame starts while high
- tape_addr  out  AW  byte-store read address
- tape_rd  out  1  byte-store read strobe; data is valid one clock later
- tape_data  in  8  byte-store read data
- txd  out  1  serial output, idle high
- busy  out  1  high from accepted start until the last stop bit ends
- done  out  1  one-cycle pulse at the end of a pass

Behaviour:
- Reset (resetn low at a clock edge, highest priority):
  - state=IDLE, txd=1, busy=0, done=0, tape_rd=0, tape_addr=0, all counters 0.
  - A reset mid-frame truncates the frame immediately; txd returns high the next clock.
- Frame format, LSB first:
  - start bit (0), d0..d7, then STOP_BITS stop bits (1).
  - Each bit lasts exactly DIVISOR clocks.
  - Frame length = (10 + STOP_BITS − 1) × DIVISOR clocks.
- States:
  - IDLE → LEAD on `start` (ignored when busy). On acceptance: latch `tape_len`, set busy the next clock, clear the byte index.
  - LEAD: send LEADER_LEN frames of 8'o200. If LEADER_LEN=0, go directly to FETCH.
  - FETCH:
    - If index == latched length → TRAIL.
    - Otherwise assert tape_rd for exactly one clock with tape_addr=index → WAITD.
  - WAITD: capture `tape_data` into the shift register one clock after tape_rd; index+1 → SEND.
  - SEND: shift out one frame, then → FETCH.
  - TRAIL: send LEADER_LEN frames of 8'o200 → DONE.
  - DONE: done=1 for one clock, busy=0 → IDLE.
- Frame-boundary timing:
  - The first start bit of a pass begins exactly 2 clocks after the accepted start pulse.
  - Between consecutive data frames exactly 2 idle-high clocks occur (FETCH + WAITD).
  - Leader and trailer frames are back-to-back, with 1 idle clock between them.
- Pause:
  - Sampled only at a frame boundary, before a start bit would begin.
  - While high, the block holds in its current state with txd=1.
  - Resumes the clock after pause falls.
  - A pause asserted mid-frame never distorts the frame.
- Wrap: tape_addr counts 0..tape_len−1 and never wraps. A tape_len of 2^AW−1 is the maximum.
- Simultaneous start and pause: start is accepted; the first frame waits for pause to fall.
- Bit timer:
  - Counts 0..DIVISOR−1; the bit advances at DIVISOR−1.
  - The timer is cleared on every state entry.

Decomposition:
- Shared package: state encodings (IDLE, LEAD, FETCH, WAITD, SEND, TRAIL, DONE) and the LEADER_BYTE constant 8'o200.
- One natural sub-module: `uart_frame_tx`.
  - Ports: `load` pulse, 8-bit data, txd, `frame_busy`.
  - Parameterised by DIVISOR and STOP_BITS.
  - The top FSM sequences bytes into it.

Test Plan:
- DIVISOR=4, STOP_BITS=2, LEADER_LEN=2, tape_len=3, store={8'h41,8'h00,8'hFF}, start pulse:
  - txd shows 0200, 0200, 41, 00, FF, 0200, 0200 (LSB first), each frame 44 clocks.
  - Data frames are separated by 2 high clocks; done pulses once; busy falls on the same clock as done.
- tape_len=0, LEADER_LEN=0, start:
  - busy high, then done after ≤3 clocks; txd stays high; tape_rd never asserts.
- pause raised during d3 of the second data frame:
  - That frame completes unaltered; the next start bit is delayed until 1 clock after pause falls.
- resetn low during d5 of a data frame:
  - Next clock txd=1, busy=0, tape_addr=0.
  - A subsequent start replays the tape from address 0.
- start pulsed while busy:
  - Ignored; tape_len change is not latched; output stream is identical to an undisturbed run.
- Loopback: txd connected to the KL8E receiver at DIVISOR=10417, 8-byte RIM tape:
  - CPU KSF/KRB reads all 8 bytes in order with no framing errors.
